// File: rtl/sha256_job_scheduler_if.sv
// sha256_job_scheduler_if: job, completion and engine-control signals of the scheduler
// job_*  : descriptor offer (valid/ready) carrying message addr, output addr, tag
// cmp_*  : completion record (valid/ready) carrying tag and start-timeout error
// core_* : engine start pulse, engine addresses, engine level done (high = idle)
interface sha256_job_scheduler_if #(parameter int TAG_W = 4);
  logic job_valid;
  logic job_ready;
  logic [15:0] job_message_addr;
  logic [15:0] job_output_addr;
  logic [TAG_W-1:0] job_tag;
  logic cmp_valid;
  logic cmp_ready;
  logic [TAG_W-1:0] cmp_tag;
  logic cmp_error;
  logic core_start;
  logic [15:0] core_message_addr;
  logic [15:0] core_output_addr;
  logic core_done;
  modport master (
    output job_valid, job_message_addr, job_output_addr, job_tag, cmp_ready, core_done,
    input job_ready, cmp_valid, cmp_tag, cmp_error, core_start, core_message_addr, core_output_addr
  );
  modport slave (
    input job_valid, job_message_addr, job_output_addr, job_tag, cmp_ready, core_done,
    output job_ready, cmp_valid, cmp_tag, cmp_error, core_start, core_message_addr, core_output_addr
  );
endinterface

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: queues hash descriptors and runs them one at a time on a single sha256 engine
// clk, reset      : clock, synchronous active-high reset
// bus (slave)     : job offer in, completion record out, engine start/addresses out, engine done in
// busy            : scheduler is not idle
// queue_count     : descriptors waiting in the queue
// jobs_completed  : completion handshakes since reset (wraps)
module sha256_job_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TAG_W         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  sha256_job_scheduler_if.slave bus,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] queue_count,
  output logic [15:0] jobs_completed
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, REPORT} state_t;
  state_t state;
  logic [15:0] msg_q [FIFO_DEPTH];
  logic [15:0] out_q [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TAG_W-1:0] job_tag_r;
  logic [TW-1:0] cnt;
  logic push, pop;
  assign bus.job_ready = queue_count < CW'(FIFO_DEPTH);
  assign push = bus.job_valid && bus.job_ready;
  assign pop = (state == IDLE) && (queue_count != '0) && bus.core_done;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (push) begin
      msg_q[wr_ptr] <= bus.job_message_addr;
      out_q[wr_ptr] <= bus.job_output_addr;
      tag_q[wr_ptr] <= bus.job_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_count <= '0;
      job_tag_r <= '0;
      cnt <= '0;
      bus.core_start <= 1'b0;
      bus.core_message_addr <= '0;
      bus.core_output_addr <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_error <= 1'b0;
      bus.cmp_tag <= '0;
      jobs_completed <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      queue_count <= queue_count + CW'(push) - CW'(pop);
      case (state)
        IDLE: if (pop) begin
          bus.core_message_addr <= msg_q[rd_ptr];
          bus.core_output_addr <= out_q[rd_ptr];
          job_tag_r <= tag_q[rd_ptr];
          bus.core_start <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          bus.core_start <= 1'b0;
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.core_done) state <= WAIT_DONE;
        else if (cnt == TMAX) begin
          bus.cmp_error <= 1'b1;
          bus.cmp_valid <= 1'b1;
          bus.cmp_tag <= job_tag_r;
          state <= REPORT;
        end else cnt <= cnt + TW'(1);
        WAIT_DONE: if (bus.core_done) begin
          bus.cmp_error <= 1'b0;
          bus.cmp_valid <= 1'b1;
          bus.cmp_tag <= job_tag_r;
          state <= REPORT;
        end
        REPORT: if (bus.cmp_ready) begin
          bus.cmp_valid <= 1'b0;
          jobs_completed <= jobs_completed + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_job_scheduler.sv
// tb_sha256_job_scheduler: directed and randomized checks of the job scheduler against a queue-based model
module tb_sha256_job_scheduler;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int START_TIMEOUT = 16;
  typedef struct packed {
    logic [15:0] m;
    logic [15:0] o;
    logic [TAG_W-1:0] t;
  } job_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] queue_count;
  logic [15:0] jobs_completed;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  sha256_job_scheduler_if #(.TAG_W(TAG_W)) bus();
  sha256_job_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .queue_count(queue_count),
    .jobs_completed(jobs_completed)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // engine stand-in: after a start it idles for pend cycles, then runs (done low) for run cycles
  bit eng_dead = 0, eng_force_busy = 0, eng_rand = 0;
  int eng_delay = 0, eng_len = 5, pend = 0, run = 0;
  initial begin
    bus.core_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.core_start) begin
        pend = eng_rand ? (($urandom_range(0, 7) == 0) ? int'($urandom_range(0, START_TIMEOUT + 3)) : int'($urandom_range(0, 2))) : eng_delay;
        run = eng_rand ? int'($urandom_range(1, 20)) : eng_len;
      end
      if (eng_force_busy) bus.core_done = 1'b0;
      else if (eng_dead) bus.core_done = 1'b1;
      else if (pend > 0) begin pend--; bus.core_done = 1'b1; end
      else if (run > 0) begin run--; bus.core_done = 1'b0; end
      else bus.core_done = 1'b1;
    end
  end
  // reference model: a job queue plus the life of the one job in flight, measured in edges since launch
  job_t fq[$];
  job_t cur, nj;
  bit m_ok = 0, m_active = 0, m_left = 0, m_rep = 0, m_push;
  int m_age = 0;
  logic m_start = 0, m_cvalid = 0, m_cerr = 0;
  logic [TAG_W-1:0] m_ctag = '0;
  logic [15:0] m_maddr = '0, m_oaddr = '0, m_done = '0;
  task automatic finish_job(input logic e);
    m_active = 0;
    m_rep = 1;
    m_cvalid = 1;
    m_cerr = e;
    m_ctag = cur.t;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      m_ok = 1; m_active = 0; m_rep = 0; m_left = 0;
      m_start = 0; m_cvalid = 0; m_cerr = 0; m_ctag = '0;
      m_maddr = '0; m_oaddr = '0; m_done = '0;
    end else if (m_ok) begin
      m_push = bus.job_valid && (fq.size() < FIFO_DEPTH);
      nj = '{m: bus.job_message_addr, o: bus.job_output_addr, t: bus.job_tag};
      m_start = 0;
      if (m_rep) begin
        if (bus.cmp_ready) begin m_rep = 0; m_cvalid = 0; m_done = m_done + 16'd1; end
      end else if (m_active) begin
        m_age++;
        // edge 1 after launch only ends the start pulse; from edge 2 on the job watches core_done
        if (m_age >= 2) begin
          if (m_left) begin
            if (bus.core_done) finish_job(1'b0);
          end else if (!bus.core_done) m_left = 1;
          else if (m_age == START_TIMEOUT + 1) finish_job(1'b1);
        end
      end else if (fq.size() > 0 && bus.core_done) begin
        cur = fq.pop_front();
        m_active = 1; m_age = 0; m_left = 0; m_start = 1;
        m_maddr = cur.m; m_oaddr = cur.o;
      end
      if (m_push) fq.push_back(nj);
    end
  end
  always @(negedge clk) begin
    if (m_ok) begin
      check("job_ready", bus.job_ready, fq.size() < FIFO_DEPTH);
      check("queue_count", queue_count, fq.size());
      check("busy", busy, m_active || m_rep);
      check("core_start", bus.core_start, m_start);
      check("core_message_addr", bus.core_message_addr, m_maddr);
      check("core_output_addr", bus.core_output_addr, m_oaddr);
      check("cmp_valid", bus.cmp_valid, m_cvalid);
      check("cmp_tag", bus.cmp_tag, m_ctag);
      check("cmp_error", bus.cmp_error, m_cerr);
      check("jobs_completed", jobs_completed, m_done);
    end
  end
  logic [TAG_W-1:0] got[$];
  bit got_err[$];
  always @(posedge clk) begin
    if (!reset && bus.cmp_valid && bus.cmp_ready) begin
      got.push_back(bus.cmp_tag);
      got_err.push_back(bus.cmp_error);
    end
  end
  task automatic push_job(input logic [15:0] m, input logic [15:0] o, input logic [TAG_W-1:0] tg);
    int i = 0;
    bus.job_valid = 1'b1;
    bus.job_message_addr = m;
    bus.job_output_addr = o;
    bus.job_tag = tg;
    while (!bus.job_ready && i < 500) begin @(negedge clk); i++; end
    check("push_accept", bus.job_ready, 1);
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((busy || queue_count != 0 || bus.cmp_valid) && i < 2000) begin @(negedge clk); i++; end
    check("wait_idle", busy, 0);
  endtask
  task automatic wait_got(input int n);
    int i = 0;
    while (got.size() < n && i < 1000) begin @(negedge clk); i++; end
    check("completion_count", got.size(), n);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    logic [15:0] jc;
    bus.job_valid = 1'b0;
    bus.job_message_addr = '0;
    bus.job_output_addr = '0;
    bus.job_tag = '0;
    bus.cmp_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_queue_count", queue_count, 0);
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_cmp_valid", bus.cmp_valid, 0);
    check("rst_jobs_completed", jobs_completed, 0);
    // single job
    eng_len = 100; eng_delay = 0;
    push_job(16'h0000, 16'h0100, 3);
    check("t1_start_early", bus.core_start, 0);
    @(negedge clk);
    check("t1_start", bus.core_start, 1);
    check("t1_maddr", bus.core_message_addr, 16'h0000);
    check("t1_oaddr", bus.core_output_addr, 16'h0100);
    @(negedge clk);
    check("t1_start_pulse", bus.core_start, 0);
    k = 0;
    while (!bus.cmp_valid && k < 300) begin @(negedge clk); k++; end
    check("t1_cmp_valid", bus.cmp_valid, 1);
    check("t1_cmp_tag", bus.cmp_tag, 3);
    check("t1_cmp_error", bus.cmp_error, 0);
    @(negedge clk);
    check("t1_jobs_completed", jobs_completed, 1);
    wait_idle();
    // queue full under completion backpressure
    got.delete(); got_err.delete();
    bus.cmp_ready = 1'b0; eng_len = 5;
    for (int t = 1; t <= 5; t++) push_job(16'h1000 + 16'(t), 16'h2000 + 16'(t), TAG_W'(t));
    repeat (20) @(negedge clk);
    check("t2_queue_count", queue_count, 4);
    check("t2_job_ready", bus.job_ready, 0);
    check("t2_cmp_tag_head", bus.cmp_tag, 1);
    bus.cmp_ready = 1'b1;
    wait_got(5);
    for (int i = 0; i < 5; i++) if (i < got.size()) check("t2_order", got[i], i + 1);
    wait_idle();
    // engine never leaves idle
    got.delete(); got_err.delete();
    eng_dead = 1; bus.cmp_ready = 1'b0;
    push_job(16'h3000, 16'h3100, 7);
    @(negedge clk);
    check("t3_start", bus.core_start, 1);
    k = 0;
    while (!bus.cmp_valid && k < 100) begin @(negedge clk); k++; end
    check("t3_timeout_cycles", k, START_TIMEOUT + 1);
    check("t3_cmp_error", bus.cmp_error, 1);
    check("t3_cmp_tag", bus.cmp_tag, 7);
    push_job(16'h3200, 16'h3300, 8);
    bus.cmp_ready = 1'b1;
    wait_got(2);
    if (got.size() == 2) begin
      check("t3_next_tag", got[1], 8);
      check("t3_next_error", got_err[1], 1);
    end
    eng_dead = 0;
    wait_idle();
    // completion backpressure
    got.delete(); got_err.delete();
    eng_len = 3; bus.cmp_ready = 1'b0;
    push_job(16'h4000, 16'h4100, 9);
    push_job(16'h4200, 16'h4300, 10);
    k = 0;
    while (!bus.cmp_valid && k < 100) begin @(negedge clk); k++; end
    jc = jobs_completed;
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_valid", bus.cmp_valid, 1);
      check("t4_hold_tag", bus.cmp_tag, 9);
      check("t4_hold_error", bus.cmp_error, 0);
      check("t4_no_start", bus.core_start, 0);
      check("t4_hold_count", jobs_completed, jc);
    end
    bus.cmp_ready = 1'b1;
    wait_got(2);
    if (got.size() == 2) begin
      check("t4_tag0", got[0], 9);
      check("t4_tag1", got[1], 10);
    end
    check("t4_count", jobs_completed, jc + 16'd2);
    wait_idle();
    // engine busy while a job waits
    got.delete(); got_err.delete();
    eng_force_busy = 1;
    push_job(16'h5000, 16'h5100, 11);
    repeat (10) begin
      @(negedge clk);
      check("t5_no_start", bus.core_start, 0);
      check("t5_no_pop", queue_count, 1);
    end
    eng_force_busy = 0;
    wait_got(1);
    if (got.size() == 1) check("t5_tag", got[0], 11);
    wait_idle();
    // reset while the engine runs and two jobs wait
    eng_len = 50;
    push_job(16'h6000, 16'h6100, 12);
    push_job(16'h6200, 16'h6300, 13);
    push_job(16'h6400, 16'h6500, 14);
    k = 0;
    while (bus.core_done && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check("t6_queued", queue_count, 2);
    check("t6_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_queue_count", queue_count, 0);
    check("t6_busy_clear", busy, 0);
    check("t6_cmp_valid", bus.cmp_valid, 0);
    check("t6_core_start", bus.core_start, 0);
    check("t6_maddr", bus.core_message_addr, 0);
    check("t6_oaddr", bus.core_output_addr, 0);
    check("t6_cmp_tag", bus.cmp_tag, 0);
    check("t6_cmp_error", bus.cmp_error, 0);
    check("t6_jobs_completed", jobs_completed, 0);
    got.delete(); got_err.delete();
    repeat (80) @(negedge clk);
    check("t6_no_completion", got.size(), 0);
    // randomized traffic
    eng_rand = 1;
    repeat (4000) begin
      @(negedge clk);
      bus.job_valid = $urandom_range(0, 2) != 0;
      bus.job_message_addr = 16'($urandom);
      bus.job_output_addr = 16'($urandom);
      bus.job_tag = TAG_W'($urandom);
      bus.cmp_ready = $urandom_range(0, 3) != 0;
      eng_force_busy = $urandom_range(0, 15) == 0;
      reset = $urandom_range(0, 599) == 0;
    end
    @(negedge clk);
    bus.job_valid = 1'b0;
    bus.cmp_ready = 1'b1;
    eng_force_busy = 0;
    reset = 1'b0;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha256_job_scheduler.md
Name: sha256_job_scheduler

Overview:
Queues hash jobs and sequences a single simplified_sha256 engine through them, one at a time. Each job is a descriptor: message address, output address and tag. The block drives the engine's start and address inputs and watches its level-type done (high while the engine is idle). For every job it returns a tagged completion record, including an error flag if the engine never leaves idle.

Parameters:
FIFO_DEPTH, 4, job queue depth (power of 2, >=2)
TAG_W, 4, width of job tag
START_TIMEOUT, 16, cycles to wait for core_done to fall after a start pulse before flagging an error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
job_valid  in  1  descriptor offered
job_ready  out  1  queue can accept a descriptor
job_message_addr  in  16  word address of message
job_output_addr  in  16  word address for the 8-word digest
job_tag  in  TAG_W  requester tag
cmp_valid  out  1  completion record valid
cmp_ready  in  1  completion consumer ready
cmp_tag  out  TAG_W  tag of completed job
cmp_error  out  1  1 = engine failed to start (timeout)
core_start  out  1  start pulse to engine
core_message_addr  out  16  to engine message_addr
core_output_addr  out  16  to engine output_addr
core_done  in  1  engine done (high = idle)
busy  out  1  state != IDLE
queue_count  out  $clog2(FIFO_DEPTH)+1  descriptors queued
jobs_completed  out  16  count of completions handed off, wraps at 16'hFFFF->0

Behaviour:
- Reset values, applied on the clk edge while reset=1:
  - state=IDLE, FIFO emptied, queue_count=0.
  - core_start=0, cmp_valid=0, cmp_error=0, cmp_tag=0.
  - core_message_addr=0, core_output_addr=0, jobs_completed=0.
  - Reset asserted mid-job abandons the job with no completion. The engine has its own reset.
- FIFO:
  - job_ready = (queue_count < FIFO_DEPTH). There is no bypass, so job_ready is 0 when full even if a pop happens in the same cycle.
  - Push on job_valid && job_ready.
  - Pop only on the IDLE->LAUNCH transition.
  - Simultaneous push and pop leaves queue_count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- All outputs are registered.
- FSM states:
  - IDLE: when queue_count>0 and core_done=1, pop the head into the job registers (addresses, tag) and go to LAUNCH. If core_done=0, stay in IDLE and do not pop.
  - LAUNCH: core_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - If core_done=0, go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches START_TIMEOUT-1 with core_done still 1, set cmp_error=1 and go to REPORT.
  - WAIT_DONE: when core_done=1, set cmp_error=0 and go to REPORT. There is no timeout in this state; the engine runtime is unbounded.
  - REPORT:
    - cmp_valid=1, cmp_tag = job tag.
    - On cmp_ready=1: drop cmp_valid, increment jobs_completed, go to IDLE.
    - cmp_valid, cmp_tag and cmp_error are held stable while cmp_ready=0.
- core_message_addr and core_output_addr update on the IDLE->LAUNCH transition and hold until the next launch. The engine re-samples message_addr after start, so they must stay stable through WAIT_DONE.
- Latency, empty queue and idle engine:
  - Descriptor accepted at edge t -> IDLE sees it and moves to LAUNCH at edge t+1.
  - core_start is high between edges t+1 and t+2.
- Back-to-back jobs: minimum of 2 cycles from the completion handshake (REPORT->IDLE) to the next core_start.
- Jobs are processed strictly in FIFO order. Exactly one completion is produced per popped job.

Test Plan:
- Single job: push msg=16'h0000, out=16'h0100, tag=3. Model the engine with done low for 100 cycles after start. Expect: core_start one cycle, 2 cycles after acceptance, with addresses 0000/0100; cmp_valid with tag=3, error=0; jobs_completed=1.
- Queue full: hold cmp_ready=0 and push 5 jobs (tags 1-5) with FIFO_DEPTH=4. Expect job 1 launched and popped, jobs 2-5 queued (queue_count=4), job_ready=0. Then release cmp_ready. Expect completions in order 1,2,3,4,5.
- Engine never starts: core_done tied to 1, push tag=7. Expect cmp_error=1 and cmp_tag=7 exactly START_TIMEOUT cycles after WAIT_BUSY entry; FSM then continues to the next job.
- Completion backpressure: cmp_ready=0 for 10 cycles in REPORT. Expect cmp_valid, tag and error stable, no new core_start, and jobs_completed unchanged until the handshake.
- Engine busy at launch: core_done=0 while the queue is non-empty. Expect no pop and no core_start until core_done=1.
- Reset during WAIT_DONE with 2 jobs queued: assert reset for 1 cycle. Expect queue_count=0, state IDLE, no cmp_valid, and all outputs at reset values on the next cycle.
